// File: rtl/mod3_pkg.sv
// Shared types and helpers for the bit-serial modulo-3 framer.
package mod3_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    R0 = 2'd0,
    R1 = 2'd1,
    R2 = 2'd2
  } residue_t;

  // One step of the MSB-first residue recurrence: next = (2*r + b) mod 3.
  function automatic residue_t mod3_next(residue_t r, logic b);
    residue_t n;
    n = R0;
    case (r)
      R0:      n = b ? R1 : R0;
      R1:      n = b ? R0 : R2;
      R2:      n = b ? R2 : R1;
      default: n = R0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mod3_residue_fsm.sv
// Running modulo-3 residue of an MSB-first bit stream.
module mod3_residue_fsm
  import mod3_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       step,
  input  logic       bit_in,
  output logic [1:0] residue
);

  residue_t state;
  residue_t state_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= R0;
    end else begin
      state <= state_nxt;
    end
  end

  // clear restarts from R0; a simultaneous step advances from that fresh R0
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = step ? mod3_next(R0, bit_in) : R0;
    end else if (step) begin
      state_nxt = mod3_next(state, bit_in);
    end
  end

  assign residue = state;

endmodule

// File: rtl/serial_mod3_framer.sv
// Assembles MSB-first serial bits into words and emits each word with its
// modulo-3 residue through a one-entry valid/ready output buffer.
module serial_mod3_framer
  import mod3_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] word_out,
  output logic [1:0]       residue,
  output logic             div3,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CNT_W-1:0] div3_count
);

  localparam int unsigned BIT_CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BIT_CW-1:0] LAST_IDX = BIT_CW'(WIDTH - 1);

  logic [BIT_CW-1:0] cnt;
  logic [WIDTH-1:0]  shreg;
  logic [1:0]        fsm_res;
  residue_t          res_post;
  logic              at_last;
  logic              accept;
  logic              complete;
  logic              consume;
  logic              fsm_clear;
  logic              fsm_step;

  assign at_last   = (cnt == LAST_IDX);
  assign bit_ready = rst_n && !(at_last && word_valid && !word_ready);
  assign accept    = bit_valid && bit_ready;
  assign complete  = accept && at_last && !frame_sync;
  assign consume   = word_valid && word_ready;
  assign res_post  = mod3_next(residue_t'(fsm_res), bit_in);

  // Completion returns the FSM to R0 without stepping; frame_sync may step from R0
  assign fsm_clear = frame_sync || complete;
  assign fsm_step  = accept && !complete;

  mod3_residue_fsm u_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (fsm_clear),
    .step    (fsm_step),
    .bit_in  (bit_in),
    .residue (fsm_res)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (frame_sync) begin
      cnt   <= accept ? BIT_CW'(1) : '0;
      shreg <= accept ? WIDTH'(bit_in) : '0;
    end else if (complete) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (accept) begin
      cnt   <= cnt + BIT_CW'(1);
      shreg <= {shreg[WIDTH-2:0], bit_in};
    end
  end

  // A completing word can only be accepted when the buffer is empty or draining
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_valid <= 1'b0;
      word_out   <= '0;
      residue    <= 2'd0;
      div3       <= 1'b1;
    end else if (complete) begin
      word_valid <= 1'b1;
      word_out   <= {shreg[WIDTH-2:0], bit_in};
      residue    <= res_post;
      div3       <= (res_post == R0);
    end else if (consume) begin
      word_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div3_count <= '0;
    end else if (consume && div3 && (div3_count != '1)) begin
      div3_count <= div3_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_serial_mod3_framer.sv
// Directed bench for serial_mod3_framer with an expected-word scoreboard.
module tb_serial_mod3_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bit_in;
  logic        bit_valid;
  logic        bit_ready;
  logic        frame_sync;
  logic [7:0]  word_out;
  logic [1:0]  residue;
  logic        div3;
  logic        word_valid;
  logic        word_ready;
  logic [15:0] div3_count;

  logic        sat_bit_ready;
  logic [7:0]  sat_word_out;
  logic [1:0]  sat_residue;
  logic        sat_div3;
  logic        sat_word_valid;
  logic [1:0]  sat_count;

  typedef struct {
    logic [7:0] w;
    logic [1:0] r;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_mod3_framer #(.WIDTH(8), .CNT_W(16)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .frame_sync (frame_sync),
    .word_out   (word_out),
    .residue    (residue),
    .div3       (div3),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .div3_count (div3_count)
  );

  serial_mod3_framer #(.WIDTH(8), .CNT_W(2)) u_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (sat_bit_ready),
    .frame_sync (frame_sync),
    .word_out   (sat_word_out),
    .residue    (sat_residue),
    .div3       (sat_div3),
    .word_valid (sat_word_valid),
    .word_ready (word_ready),
    .div3_count (sat_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    exp_t e;
    e.w = w;
    e.r = 2'(int'(w) % 3);
    sb.push_back(e);
  endtask

  // Drive one bit from posedge+1 and return at posedge+1 after it is accepted.
  task automatic put_bit(input logic b, input logic fs);
    int n;
    bit_in = b;
    bit_valid = 1'b1;
    frame_sync = fs;
    n = 0;
    @(negedge clk);
    while (!bit_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("bit_accept_timeout", 32'(bit_ready), 32'd1);
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    push_word(w);
    for (int i = 7; i >= 0; i--) put_bit(w[i], 1'b0);
  endtask

  task automatic check_reset_values();
    check("rst_word_valid", 32'(word_valid), 32'd0);
    check("rst_word_out", 32'(word_out), 32'd0);
    check("rst_residue", 32'(residue), 32'd0);
    check("rst_div3", 32'(div3), 32'd1);
    check("rst_div3_count", 32'(div3_count), 32'd0);
    check("rst_bit_ready", 32'(bit_ready), 32'd1);
  endtask

  // Output monitor: compares every consumed word and the running counters.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_cnt = 0;
    end else begin
      check("div3_count", 32'(div3_count), 32'(exp_cnt));
      check("sat_count", 32'(sat_count), 32'((exp_cnt > 3) ? 3 : exp_cnt));
      check("sat_mirror",
            32'({sat_bit_ready, sat_word_valid, sat_div3, sat_residue, sat_word_out}),
            32'({bit_ready, word_valid, div3, residue, word_out}));
      if (word_valid && word_ready) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("word_out", 32'(word_out), 32'(e.w));
          check("residue", 32'(residue), 32'(e.r));
          check("div3", 32'(div3), 32'(e.r == 2'd0));
          if (e.r == 2'd0) exp_cnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int exp_sat[4];
    exp_sat = '{1, 2, 3, 3};
    rst_n = 1'b0;
    bit_in = 1'b0;
    bit_valid = 1'b0;
    frame_sync = 1'b0;
    word_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("bit_ready_in_reset", 32'(bit_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values();
    @(posedge clk);
    #1;

    // Basic word 0x06
    send_word(8'h06);
    check("basic_valid", 32'(word_valid), 32'd1);
    check("basic_word", 32'(word_out), 32'h06);
    @(posedge clk);
    #1;
    check("basic_valid_drop", 32'(word_valid), 32'd0);
    check("basic_count", 32'(div3_count), 32'd1);

    // Residues 1, 2, 0 back to back
    c0 = cyc;
    send_word(8'h07);
    send_word(8'h08);
    send_word(8'hFF);
    check("no_bubbles", 32'(cyc - c0), 32'd24);
    @(posedge clk);
    #1;
    check("cover_count", 32'(div3_count), 32'd2);

    // Back-pressure: only the last bit of 0x05 stalls
    word_ready = 1'b0;
    push_word(8'h03);
    push_word(8'h05);
    c0 = cyc;
    for (int i = 7; i >= 0; i--) put_bit(1'(8'h03 >> i), 1'b0);
    for (int i = 7; i >= 1; i--) put_bit(1'(8'h05 >> i), 1'b0);
    check("bp_no_stall", 32'(cyc - c0), 32'd15);
    bit_in = 1'b1;
    bit_valid = 1'b1;
    @(negedge clk);
    check("bp_stall", 32'(bit_ready), 32'd0);
    check("bp_hold_word", 32'(word_out), 32'h03);
    @(posedge clk);
    #1;
    word_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_comb", 32'(bit_ready), 32'd1);
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    check("bp_valid_held", 32'(word_valid), 32'd1);
    check("bp_new_word", 32'(word_out), 32'h05);
    check("bp_new_res", 32'(residue), 32'd2);
    @(posedge clk);
    #1;
    check("bp_drained", 32'(word_valid), 32'd0);

    // frame_sync discards a partial word and restarts with the sync bit
    push_word(8'h80);
    put_bit(1'b1, 1'b0);
    put_bit(1'b0, 1'b0);
    put_bit(1'b1, 1'b0);
    put_bit(1'b1, 1'b0);
    put_bit(1'b0, 1'b0);
    put_bit(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) put_bit(1'b0, 1'b0);
    check("fs_word", 32'(word_out), 32'h80);
    check("fs_residue", 32'(residue), 32'd2);
    @(posedge clk);
    #1;

    // Mid-word reset with a word pending in the buffer
    word_ready = 1'b0;
    send_word(8'h0C);
    for (int i = 0; i < 4; i++) put_bit(1'b1, 1'b0);
    check("pending_valid", 32'(word_valid), 32'd1);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_bit_ready", 32'(bit_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values();
    @(posedge clk);
    #1;
    word_ready = 1'b1;
    send_word(8'h09);
    check("post_rst_word", 32'(word_out), 32'h09);
    check("post_rst_div3", 32'(div3), 32'd1);
    @(posedge clk);
    #1;

    // Saturation on the 2-bit counter instance, starting from reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_word(8'h00);
      @(posedge clk);
      #1;
      check("sat_step", 32'(sat_count), 32'(exp_sat[k]));
    end
    repeat (2) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
